// File: rtl/audio_note_sequencer.sv
// Note-table sequencer: plays {phase increment, duration} entries into one wave generator and
// owns the 48 kHz sample-tick divider. Optional macro AUDIO_SEQ_LOOP_EN repeats the table until stopped.
module audio_note_sequencer #(
    parameter int DIV_SAMPLE = 259,
    parameter int DEPTH      = 16,
    parameter int FREQ_W     = 16,
    parameter int DUR_W      = 16
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr_i,
    input  logic [FREQ_W+DUR_W-1:0]      wr_data_i,
    input  logic [$clog2(DEPTH):0]       len_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    output logic [FREQ_W-1:0]            freq_o,
    output logic                         gate_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         tick_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DIV_SAMPLE + 1);
    localparam int EW = FREQ_W + DUR_W;
    localparam logic [AW:0]   LEN_MAX = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] DIV_MAX = CW'(DIV_SAMPLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     div_q, div_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW:0]       len_q, len_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              done_q, done_d;
    logic              rd_en;
    logic              tick;
    logic              last_note;
    logic [AW:0]       len_clamped;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     rd_q;
    logic [DUR_W-1:0]  rd_dur;

    assign tick        = (div_q == DIV_MAX);
    assign div_d       = tick ? '0 : div_q + CW'(1);
    assign len_clamped = (len_i > LEN_MAX) ? LEN_MAX : len_i;
    assign last_note   = ({1'b0, idx_q} == (len_q - (AW + 1)'(1)));
    assign rd_dur      = rd_q[DUR_W-1:0];

    // Table RAM: read is issued on the edge entering LOAD, so the entry is valid during LOAD.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en) begin
            rd_q <= mem_q[idx_d];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        dur_d   = dur_q;
        done_d  = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        len_d   = len_clamped;
                        idx_d   = '0;
                        state_d = S_LOAD;
                        rd_en   = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                dur_d   = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (tick) begin
                    if (dur_q == DUR_W'(1)) begin
                        if (last_note) begin
`ifdef AUDIO_SEQ_LOOP_EN
                            idx_d   = '0;
                            state_d = S_LOAD;
                            rd_en   = 1'b1;
                            done_d  = 1'b1;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            state_d = S_LOAD;
                            rd_en   = 1'b1;
                        end
                    end else begin
                        dur_d = dur_q - DUR_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides everything, including a start in the same cycle.
        if (stop_i) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            rd_en   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            dur_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            dur_q   <= dur_d;
            done_q  <= done_d;
        end
    end

    assign gate_o = (state_q == S_LOAD) || (state_q == S_PLAY);
    assign freq_o = gate_o ? rd_q[EW-1 -: FREQ_W] : '0;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q || (state_q == S_DONE);
    assign tick_o = tick;

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Directed bench for audio_note_sequencer: divider timing, note playback,
// stop/start interactions, zero length, length clamp, live table rewrite.
module tb_audio_note_sequencer;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [3:0]  wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic [4:0]  len_i = '0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [15:0] freq_o;
    logic        gate_o;
    logic        busy_o;
    logic        done_o;
    logic        tick_o;

    int n_total = 0;
    int n_pass  = 0;
    int exp_f [17];
    int exp_t [17];

    typedef struct {
        string name;
        int    f;
        int    d;
        int    exp_ticks;
    } vec_t;

    vec_t vecs [5];

    audio_note_sequencer dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .len_i     (len_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .freq_o    (freq_o),
        .gate_o    (gate_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .tick_o    (tick_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic wr(input int a, input int f, input int d);
        wr_en_i   = 1'b1;
        wr_addr_i = a[3:0];
        wr_data_i = {f[15:0], d[15:0]};
        cyc();
        wr_en_i   = 1'b0;
    endtask

    // Start a sequence and follow it note by note; a note boundary is the cycle freq_o changes.
    task automatic run_seq(input string tag, input int len_val, input int nexp,
                           input bit mid_wr, input int mid_addr, input int mid_f, input int mid_d);
        int  k;
        int  tcnt;
        int  c;
        int  prev;
        bit  gate_drop;
        bit  got_done;
        bit  leave;
        start_i = 1'b1;
        len_i   = len_val[4:0];
        cyc();
        start_i = 1'b0;
        len_i   = '0;
        check({tag, " load freq"}, freq_o, exp_f[0]);
        check({tag, " load gate"}, gate_o, 1);
        check({tag, " load busy"}, busy_o, 1);
        k = 0; tcnt = 0; prev = int'(freq_o);
        gate_drop = 1'b0; got_done = 1'b0; leave = 1'b0;
        for (c = 0; c < 60000 && !leave; c++) begin
            if (mid_wr && c == 4) begin
                wr_en_i   = 1'b1;
                wr_addr_i = mid_addr[3:0];
                wr_data_i = {mid_f[15:0], mid_d[15:0]};
            end else if (mid_wr && c == 5) begin
                wr_en_i = 1'b0;
            end
            cyc();
            if (done_o) begin
                got_done = 1'b1;
                leave    = 1'b1;
            end else if (!gate_o) begin
                gate_drop = 1'b1;
                leave     = 1'b1;
            end else if (int'(freq_o) != prev) begin
                check($sformatf("%s note%0d ticks", tag, k), tcnt, exp_t[k]);
                if (k < 15) k++;
                check($sformatf("%s note%0d freq", tag, k), freq_o, exp_f[k]);
                tcnt = 0;
                prev = int'(freq_o);
            end else if (tick_o) begin
                tcnt++;
            end
        end
        wr_en_i = 1'b0;
        check({tag, " done seen"}, got_done, 1);
        check({tag, " gate held"}, gate_drop, 0);
        check($sformatf("%s note%0d ticks", tag, k), tcnt, exp_t[k]);
        check({tag, " notes played"}, k + 1, nexp);
`ifdef AUDIO_SEQ_LOOP_EN
        check({tag, " wrap busy"}, busy_o, 1);
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
`else
        check({tag, " done freq"}, freq_o, 0);
        check({tag, " done gate"}, gate_o, 0);
        check({tag, " done busy"}, busy_o, 1);
        cyc();
`endif
        check({tag, " idle busy"}, busy_o, 0);
        check({tag, " idle done"}, done_o, 0);
        $display("seq %s: len=%0d notes=%0d", tag, len_val, k + 1);
    endtask

    initial begin
        int  n;
        int  c;
        bit  seen;
        int  ndone;
        int  tcnt;

        vecs[0] = '{"v_440",  4723, 40, 40};
        vecs[1] = '{"v_dur1", 9446, 1,  1};
        vecs[2] = '{"v_dur0", 2362, 0,  1};
        vecs[3] = '{"v_fmax", 65535, 3, 3};
        vecs[4] = '{"v_fmin", 1,    2,  2};

        // Reset values and divider timing
        cyc(); cyc(); cyc();
        check("rst freq", freq_o, 0);
        check("rst gate", gate_o, 0);
        check("rst busy", busy_o, 0);
        check("rst done", done_o, 0);
        check("rst tick", tick_o, 0);
        rstn_i = 1'b1;
        n = 0;
        while (!tick_o && n < 400) begin cyc(); n++; end
        check("first tick clk", n + 1, 260);
        n = 0;
        do begin cyc(); n++; end while (!tick_o && n < 400);
        check("tick period", n, 260);
        $display("reset: first tick at clk 260, period %0d", n);

        // Single-note table
        for (int i = 0; i < 5; i++) begin
            wr(0, vecs[i].f, vecs[i].d);
            exp_f[0] = vecs[i].f;
            exp_t[0] = vecs[i].exp_ticks;
            run_seq(vecs[i].name, 1, 1, 1'b0, 0, 0, 0);
        end

        // Three back-to-back notes
        wr(0, 4723, 3); wr(1, 9446, 2); wr(2, 2362, 0);
        exp_f[0] = 4723; exp_t[0] = 3;
        exp_f[1] = 9446; exp_t[1] = 2;
        exp_f[2] = 2362; exp_t[2] = 1;
        run_seq("three", 3, 3, 1'b0, 0, 0, 0);

        // Stop during entry 2, then simultaneous start and stop
        start_i = 1'b1; len_i = 5'd3;
        cyc();
        start_i = 1'b0; len_i = '0;
        c = 0;
        while (freq_o != 16'd9446 && c < 5000) begin cyc(); c++; end
        check("stop reach note2", freq_o, 9446);
        cyc(); cyc();
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        check("stop freq", freq_o, 0);
        check("stop gate", gate_o, 0);
        check("stop busy", busy_o, 0);
        check("stop done", done_o, 0);
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (done_o || busy_o) seen = 1'b1;
        end
        check("stop quiet", seen, 0);
        start_i = 1'b1; stop_i = 1'b1; len_i = 5'd3;
        cyc();
        start_i = 1'b0; stop_i = 1'b0; len_i = '0;
        check("start+stop busy", busy_o, 0);
        check("start+stop gate", gate_o, 0);
        cyc();
        check("start+stop busy2", busy_o, 0);
        check("start+stop done", done_o, 0);
        $display("stop: aborted in note 2, start+stop ignored");

        // Zero length start
        start_i = 1'b1; len_i = 5'd0;
        cyc();
        start_i = 1'b0;
        check("len0 done", done_o, 1);
        check("len0 busy", busy_o, 0);
        cyc();
        check("len0 done end", done_o, 0);
        check("len0 busy end", busy_o, 0);
        $display("len0: done pulse without busy");

        // Rewrite entry 1 while entry 0 plays
        wr(0, 1000, 3); wr(1, 2000, 1);
        exp_f[0] = 1000; exp_t[0] = 3;
        exp_f[1] = 3000; exp_t[1] = 2;
        run_seq("rewrite", 2, 2, 1'b1, 1, 3000, 2);

        // Length above DEPTH clamps to the full table
        for (int i = 0; i < 16; i++) begin
            wr(i, 100 + i, 1);
            exp_f[i] = 100 + i;
            exp_t[i] = 1;
        end
        run_seq("clamp", 31, 16, 1'b0, 0, 0, 0);

        // Two entries of two ticks each
        wr(0, 5000, 2); wr(1, 6000, 2);
        start_i = 1'b1; len_i = 5'd2;
        cyc();
        start_i = 1'b0; len_i = '0;
        ndone = 0; tcnt = 0; seen = 1'b0;
        for (c = 0; c < 8000 && ndone < 3; c++) begin
            cyc();
            if (done_o) begin
`ifdef AUDIO_SEQ_LOOP_EN
                if (ndone > 0) check($sformatf("loop wrap%0d ticks", ndone), tcnt, 4);
`endif
                ndone++;
                tcnt = 0;
            end else if (tick_o) begin
                tcnt++;
            end
`ifdef AUDIO_SEQ_LOOP_EN
            if (!busy_o) seen = 1'b1;
`endif
        end
`ifdef AUDIO_SEQ_LOOP_EN
        check("loop dones", ndone, 3);
        check("loop busy held", seen, 0);
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        check("loop stop busy", busy_o, 0);
`else
        check("single pass dones", ndone, 1);
        check("single pass busy", busy_o, 0);
`endif
        $display("two-entry run: %0d done pulses", ndone);

        // Asynchronous reset mid-sequence restarts the divider phase
        start_i = 1'b1; len_i = 5'd2;
        cyc();
        start_i = 1'b0; len_i = '0;
        for (int i = 0; i < 10; i++) cyc();
        check("pre-reset busy", busy_o, 1);
        #2 rstn_i = 1'b0;
        #1;
        check("async rst busy", busy_o, 0);
        check("async rst gate", gate_o, 0);
        check("async rst freq", freq_o, 0);
        cyc();
        rstn_i = 1'b1;
        n = 0;
        while (!tick_o && n < 400) begin cyc(); n++; end
        check("post-reset first tick clk", n + 1, 260);
        $display("async reset: outputs cleared, divider restarted");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
